// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: FWFT FIFO of {pc, instr} between IF and ID; emits a NOP when empty and is cleared by flush.
module inst_prefetch_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_instr,
    output logic              if_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_instr,
    input  logic              id_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("inst_prefetch_queue: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W+DATA_W-1:0] head;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic                     push;
    logic                     pop;

    assign full     = count == CNT_W'(DEPTH);
    assign empty    = count == '0;
    assign if_ready = !full;
    assign id_valid = !empty;
    assign push     = if_valid & if_ready & !flush;
    assign pop      = id_valid & id_ready & !flush;
    assign head     = mem[rd_ptr];
    assign id_pc    = empty ? '0 : head[DATA_W +: ADDR_W];
    assign id_instr = empty ? '0 : head[DATA_W-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {if_pc, if_instr};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    a_count_bound: assert property (@(posedge clock) disable iff (!reset) count <= CNT_W'(DEPTH));
endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Parametrised instruction prefetch buffer between the IF and ID stages of the multistage pipeline.
- Replaces the single IF/ID instruction register with a DEPTH-entry FIFO of {pc, instr} pairs.
- Fetch keeps running while ID is stalled.
- A flush input discards all queued entries on branch/jump/JR redirect.
- When the queue is empty, the ID-side instruction output is a NOP (all zeros), so the controller decodes harmless control signals.

Parameters:
- DATA_W, 32, instruction width in bits.
- ADDR_W, 32, PC width in bits.
- DEPTH, 4, number of entries. Must be a power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear (redirect from branch/jump/JR resolution).
- if_valid  in  1  fetch stage presents an entry.
- if_pc  in  ADDR_W  PC of the presented instruction.
- if_instr  in  DATA_W  instruction word from instruction memory.
- if_ready  out  1  queue accepts an entry this cycle.
- id_valid  out  1  head entry is valid.
- id_pc  out  ADDR_W  PC of the head entry.
- id_instr  out  DATA_W  head instruction word.
- id_ready  in  1  ID stage consumes the head this cycle (low = ID stall).
- count  out  CNT_W  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Storage:
  - DEPTH x (ADDR_W+DATA_W) register array.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count register is CNT_W bits.
- Reset (reset==0, asynchronous):
  - wr_ptr = rd_ptr = count = 0; all storage cleared to 0.
  - Outputs: if_ready=1, id_valid=0, id_pc=0, id_instr=0, count=0, full=0, empty=1.
  - When reset is deasserted, normal operation starts at the next rising edge.
- Handshake:
  - if_ready = !full. There is no pass-through when full, even if id_ready=1.
  - push = if_valid & if_ready & !flush.
  - id_valid = !empty.
  - pop = id_valid & id_ready & !flush.
- Read side is first-word-fall-through:
  - id_pc and id_instr show storage[rd_ptr] combinationally when !empty.
  - When empty, id_pc=0 and id_instr=0 (NOP).
- Latency:
  - An entry pushed at edge N appears on the id_* outputs immediately after edge N.
  - There is no same-cycle bypass from if_* to id_*.
- Per rising edge, in priority order:
  1. flush=1: wr_ptr=rd_ptr=count=0. Any concurrent push or pop is ignored. Storage contents are don't-care.
  2. push & pop: write at wr_ptr, advance both pointers, count unchanged. Possible only when 0 < count < DEPTH.
  3. push only: write at wr_ptr, wr_ptr+1, count+1.
  4. pop only: rd_ptr+1, count-1.
  5. neither: all state held. With id_ready=0, the head stays stable indefinitely.
- Boundaries:
  - Full: if_valid is ignored (if_ready=0). Pop still proceeds, and if_ready rises the cycle after.
  - Empty: id_ready is ignored (no pop). Count never underflows or overflows.
- Order: strict FIFO. Entries exit in push order, including across pointer wrap.
- Reset mid-operation: all entries are lost immediately, with no wait for a clock edge. Outputs take their reset values while reset is low.
- full, empty and count are decoded from the count register only. There is no combinational path from if_* to id_*.
- Parameter checks:
  - Elaboration-time error if DEPTH is not a power of two or is < 2.
  - Simulation assertion that count <= DEPTH at all times.

Test Plan:
- Reset/NOP:
  - Stimulus: hold reset=0 for 2 cycles with if_valid=1, if_instr=32'h2008_0005.
  - Required: id_valid=0, id_instr=0, empty=1, if_ready=1, count=0. After release, the first edge pushes the entry and id_instr=32'h2008_0005 with id_valid=1.
- Fill/stall:
  - Setup: DEPTH=4, id_ready=0, push PCs 0x00,0x04,0x08,0x0C.
  - Required: count steps 1,2,3,4; full=1, if_ready=0. A fifth if_valid (pc 0x10) is not stored. id_pc stays 0x00 throughout.
- Drain order/wrap:
  - Stimulus: stream 10 entries (pc 0x00..0x24) with if_valid=1 and id_ready toggling 1,0,1,...
  - Required: id_pc sequence 0x00,0x04,...,0x24 with no loss or duplication. Pointers wrap at least twice, and count never exceeds 4.
- Simultaneous push/pop:
  - Stimulus: at count=2, hold if_valid=1 and id_ready=1 for 5 cycles.
  - Required: count stays 2 and the head advances one entry per cycle.
- Flush priority:
  - Stimulus: at count=3, assert flush with if_valid=1 and id_ready=1 in the same cycle.
  - Required: the next cycle has count=0, empty=1, id_instr=0, and the concurrent entry is not stored. The next push appears at the head.
- Reset mid-operation:
  - Stimulus: at count=3, drop reset between clock edges.
  - Required: count=0, id_valid=0 and id_instr=0 immediately, without waiting for an edge. After release, the queue refills correctly from wr_ptr=0.
